// File: rtl/arb4_pkg.sv
// Shared types and helpers for the four-requester arbiter.
package arb4_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {IDLE, OFFER} state_e;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    onehot4      = '0;
    onehot4[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational picker: first set bit of vec starting at ptr (mod-4 wrap).
// With ARB_FIXED_PRIO_EN defined it picks the highest set index and ignores ptr.
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = 0; i < NUM_REQ; i++)
      if (vec[i]) idx = IDX_W'(i);
  end
`else
  logic [IDX_W-1:0] cand;

  // Walk the search order backwards so the slot at ptr itself has final say.
  always_comb begin
    idx  = '0;
    any  = |vec;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (vec[cand]) idx = cand;
    end
  end
`endif
endmodule

// File: rtl/req_arb4.sv
// Four-requester arbiter: sticky request capture, round-robin (or fixed, under
// ARB_FIXED_PRIO_EN) grant selection, valid/ready handshake with optional timeout.
module req_arb4
  import arb4_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_pulse,
  input  logic               grant_ready,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] pending,
  output logic               timeout
);
`ifdef ARB_FIXED_PRIO_EN
  localparam bit USE_PTR = 1'b0;
`else
  localparam bit USE_PTR = 1'b1;
`endif

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic               gvld_q, gvld_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic               tout_q, tout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept, tmo_hit, pick_any;
  logic [NUM_REQ-1:0] clr, rem, pick_vec;
  logic [IDX_W-1:0]   ptr_nx, pick_ptr, pick_idx;

  always_comb begin
    accept   = gvld_q & grant_ready;
    clr      = accept ? onehot4(gidx_q) : '0;
    // Set wins: a fresh pulse re-arms a bit being cleared this cycle.
    pend_d   = (pend_q & ~clr) | req_pulse;
    rem      = pend_q & ~onehot4(gidx_q);
    ptr_nx   = gidx_q + IDX_W'(1);
    pick_vec = (state_q == IDLE) ? pend_q : rem;
    pick_ptr = (state_q == IDLE) ? ptr_q  : ptr_nx;
    tmo_hit  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1)) && !accept;
  end

  rr_pick4 u_pick (
    .vec (pick_vec),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gvld_d  = gvld_q;
    tout_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gidx_d  = pick_idx;
          gvld_d  = 1'b1;
          cnt_d   = '0;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          if (USE_PTR) ptr_d = ptr_nx;
          cnt_d = '0;
          if (pick_any) begin
            gidx_d = pick_idx;
          end else begin
            gvld_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          // Withdraw but keep the pending bit; the requester gets another turn.
          if (USE_PTR) ptr_d = ptr_nx;
          gvld_d  = 1'b0;
          tout_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gvld_q  <= 1'b0;
      pend_q  <= '0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gvld_q  <= gvld_d;
      pend_q  <= pend_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_valid = gvld_q;
  assign grant_idx   = gidx_q;
  assign pending     = pend_q;
  assign timeout     = tout_q;
endmodule
